// File: rtl/match_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : match_ctrl_if
// Description : Control/status bundle between the game logic and match_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_ctrl_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int GRID_CELLS  = 256,
    parameter int COR_W       = 8,
    parameter int SCORE_W     = 3,
    parameter int IDX_W       = $clog2(NUM_PLAYERS)
) ();
    logic                           i_tick;
    logic                           i_start;
    logic                           i_begin;
    logic [GRID_CELLS-1:0]          i_explode;
    logic [NUM_PLAYERS*COR_W-1:0]   i_cor;
    logic [2:0]                     o_state;
    logic [NUM_PLAYERS-1:0]         o_alive;
    logic [IDX_W-1:0]               o_winner;
    logic                           o_draw;
    logic [NUM_PLAYERS*SCORE_W-1:0] o_scores;
    logic                           o_round_start;

    modport master (
        output i_tick, i_start, i_begin, i_explode, i_cor,
        input  o_state, o_alive, o_winner, o_draw, o_scores, o_round_start
    );

    modport slave (
        input  i_tick, i_start, i_begin, i_explode, i_cor,
        output o_state, o_alive, o_winner, o_draw, o_scores, o_round_start
    );
endinterface
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : match_ctrl
// Description : Multi-round bomb-game match controller: elimination, round
//               end / draw detection, round-over display timing and scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module match_ctrl #(
    parameter int NUM_PLAYERS       = 4,
    parameter int GRID_CELLS        = 256,
    parameter int COR_W             = 8,
    parameter int ROUND_OVER_FRAMES = 60,
    parameter int ROUNDS_TO_WIN     = 3,
    parameter int SCORE_W           = 3,
    parameter int IDX_W             = $clog2(NUM_PLAYERS)
) (
    input  logic        clk,
    input  logic        reset,
    match_ctrl_if.slave bus
);
    localparam int                 CNT_W       = (ROUND_OVER_FRAMES > 1) ? $clog2(ROUND_OVER_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST  = CNT_W'(ROUND_OVER_FRAMES - 1);
    localparam logic [SCORE_W-1:0] C_SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] C_SCORE_WIN = SCORE_W'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        ST_STARTING   = 3'd0,
        ST_OPTION     = 3'd1,
        ST_PLAYING    = 3'd2,
        ST_ROUND_OVER = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [NUM_PLAYERS-1:0]     alive_q, alive_d;
    logic [IDX_W-1:0]           winner_q, winner_d;
    logic                       draw_q, draw_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic                       round_start_q, round_start_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic [NUM_PLAYERS-1:0]     w_hit;
    logic [NUM_PLAYERS-1:0]     w_alive_next;
    logic [IDX_W:0]             w_n_alive;
    logic [IDX_W-1:0]           w_surv;
    logic [NUM_PLAYERS*SCORE_W-1:0] w_scores_inc;
    logic                       w_win_any;
    logic [IDX_W-1:0]           w_win_idx;

    // Coordinates beyond the map match no cell, so such players are never hit.
    always_comb begin
        w_hit = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int k = 0; k < GRID_CELLS; k++) begin
                if (bus.i_cor[p*COR_W +: COR_W] == COR_W'(k) && bus.i_explode[k]) begin
                    w_hit[p] = alive_q[p];
                end
            end
        end
    end

    always_comb begin
        w_alive_next = alive_q & ~w_hit;
        w_n_alive    = '0;
        w_surv       = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_alive_next[p]) begin
                w_n_alive = w_n_alive + (IDX_W+1)'(1);
                w_surv    = IDX_W'(p);
            end
        end

        w_scores_inc = scores_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (IDX_W'(p) == w_surv && scores_q[p*SCORE_W +: SCORE_W] != C_SCORE_MAX) begin
                w_scores_inc[p*SCORE_W +: SCORE_W] = scores_q[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
            end
        end

        // Descending scan leaves the lowest qualifying index.
        w_win_any = 1'b0;
        w_win_idx = '0;
        for (int p = NUM_PLAYERS-1; p >= 0; p--) begin
            if (scores_q[p*SCORE_W +: SCORE_W] >= C_SCORE_WIN) begin
                w_win_any = 1'b1;
                w_win_idx = IDX_W'(p);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        alive_d       = alive_q;
        winner_d      = winner_q;
        draw_d        = draw_q;
        scores_d      = scores_q;
        round_start_d = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            ST_STARTING: begin
                if (bus.i_start) state_d = ST_OPTION;
            end
            ST_OPTION: begin
                if (bus.i_begin) begin
                    state_d       = ST_PLAYING;
                    scores_d      = '0;
                    alive_d       = '1;
                    draw_d        = 1'b0;
                    winner_d      = '0;
                    round_start_d = 1'b1;
                end
            end
            ST_PLAYING: begin
                alive_d = w_alive_next;
                if (w_n_alive <= (IDX_W+1)'(1)) begin
                    state_d = ST_ROUND_OVER;
                    cnt_d   = '0;
                    if (w_n_alive == (IDX_W+1)'(1)) begin
                        winner_d = w_surv;
                        draw_d   = 1'b0;
                        scores_d = w_scores_inc;
                    end else begin
                        draw_d   = 1'b1;
                    end
                end
            end
            ST_ROUND_OVER: begin
                if (bus.i_tick) begin
                    if (cnt_q == C_CNT_LAST) begin
                        cnt_d = '0;
                        if (w_win_any) begin
                            state_d  = ST_MATCH_OVER;
                            winner_d = w_win_idx;
                        end else begin
                            state_d       = ST_PLAYING;
                            alive_d       = '1;
                            round_start_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_MATCH_OVER: begin
                if (bus.i_start) state_d = ST_OPTION;
            end
            default: begin
                state_d = ST_STARTING;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_STARTING;
            alive_q       <= '1;
            winner_q      <= '0;
            draw_q        <= 1'b0;
            scores_q      <= '0;
            round_start_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            alive_q       <= alive_d;
            winner_q      <= winner_d;
            draw_q        <= draw_d;
            scores_q      <= scores_d;
            round_start_q <= round_start_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.o_state       = state_q;
    assign bus.o_alive       = alive_q;
    assign bus.o_winner      = winner_q;
    assign bus.o_draw        = draw_q;
    assign bus.o_scores      = scores_q;
    assign bus.o_round_start = round_start_q;
endmodule
`default_nettype wire

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
- Parametrised match controller for the bomb game.
- Tracks N players across a multi-round match:
  - eliminates players whose grid cell is exploding;
  - detects round end, including a draw;
  - holds a frame-counted round-over display;
  - keeps per-player round scores;
  - declares the match winner once a player reaches the target number of round wins.
- Sits between the explosion map / player-position logic and the VGA/scene selector, which decodes `o_state`.

Parameters:
- NUM_PLAYERS, 4, number of players (2..8).
- GRID_CELLS, 256, number of cells in the explosion map.
- COR_W, 8, width of one player coordinate; must satisfy 2^COR_W >= GRID_CELLS.
- ROUND_OVER_FRAMES, 60, number of `i_tick` pulses the ROUND_OVER state is held (>=1).
- ROUNDS_TO_WIN, 3, round wins needed to win the match (1..2^SCORE_W-1).
- SCORE_W, 3, width of one score field.
- IDX_W, $clog2(NUM_PLAYERS), width of a player index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_tick  in  1  frame tick, one-cycle pulse per video frame.
- i_start  in  1  leave title screen; restart from match-over screen.
- i_begin  in  1  leave option screen and start the match.
- i_explode  in  GRID_CELLS  bit k = cell k currently exploding.
- i_cor  in  NUM_PLAYERS*COR_W  player p coordinate in bits [p*COR_W +: COR_W].
- o_state  out  3  0 STARTING, 1 OPTION, 2 PLAYING, 3 ROUND_OVER, 4 MATCH_OVER.
- o_alive  out  NUM_PLAYERS  bit p = player p alive this round.
- o_winner  out  IDX_W  last round winner; match winner while in MATCH_OVER.
- o_draw  out  1  last round ended with no survivor.
- o_scores  out  NUM_PLAYERS*SCORE_W  player p round wins in bits [p*SCORE_W +: SCORE_W].
- o_round_start  out  1  one-cycle pulse on entry to PLAYING; downstream uses it to clear the map and respawn players.

Behaviour:
- All outputs are registered.
- Reset values: o_state=STARTING, o_alive=all 1s, o_winner=0, o_draw=0, o_scores=0, o_round_start=0. The internal tick counter is also cleared.
- Reset is asynchronous and may arrive in any state; it aborts the match with no residual score.
- STARTING: on i_start=1, go to OPTION next cycle.
- OPTION: on i_begin=1, go to PLAYING.
  - In the same cycle: clear scores, set o_alive=all 1s, o_draw=0, o_winner=0, and pulse o_round_start.
- PLAYING: each cycle, compute hit[p] = o_alive[p] & i_explode[cor_p].
  - A coordinate >= GRID_CELLS is never hit.
  - Next alive = o_alive & ~hit.
  - Dead players never revive within a round, even if later off-explosion.
- Round-end check, on next alive:
  - popcount <= 1 → go to ROUND_OVER next cycle; the counter is cleared.
  - Exactly one survivor q: o_winner=q, o_draw=0, and score[q] increments, saturating at 2^SCORE_W-1.
  - Zero survivors (simultaneous hits in the same cycle): o_draw=1, o_winner unchanged, no score change.
- ROUND_OVER:
  - The counter increments only on cycles with i_tick=1.
  - On the cycle where i_tick=1 and counter==ROUND_OVER_FRAMES-1, leave the state; the display therefore lasts exactly ROUND_OVER_FRAMES ticks.
  - Exit to MATCH_OVER if any score >= ROUNDS_TO_WIN. o_winner then becomes the lowest-index player meeting this; only the round winner can newly meet it.
  - Otherwise exit to PLAYING: o_alive=all 1s and o_round_start pulses. Scores and o_draw are held until the next round ends.
  - i_explode is ignored in this state.
- MATCH_OVER: hold all outputs. On i_start=1, go to OPTION; scores are kept until i_begin.
- i_start/i_begin are ignored outside their states. i_tick is ignored outside ROUND_OVER.
- Undefined o_state encodings (5..7) go to STARTING next cycle.

Test Plan:
1. Reset, then i_start, then i_begin → o_state 0→1→2; o_round_start high one cycle; o_alive=4'b1111; scores 0.
2. In PLAYING, players at cells 5/17/40/200; set explode bits 5 and 17, then 40 two cycles later → alive 1111→1100→1000; ROUND_OVER; o_winner=3; score3=1; o_draw=0.
3. In ROUND_OVER with i_tick every 4th cycle → state stays 3 for exactly 60 ticks (extra idle cycles don't count), then returns to 2 with o_round_start pulse and o_alive=1111.
4. Last two alive players (cells 10, 11) with explode bits 10 and 11 set in the same cycle → ROUND_OVER, o_draw=1, no score change, o_winner unchanged.
5. Player 1 wins three rounds → after 60 ticks of the third ROUND_OVER, state=4 and o_winner=1. i_start → OPTION; i_begin clears scores to 0.
6. Assert reset mid-ROUND_OVER with scores 2/1 → all outputs return to reset values immediately (async). Also check a player at coordinate 255 with GRID_CELLS=200 is never eliminated.
